// File: rtl/mul_div_unit_pkg.sv
// Shared opcode definitions and decode helpers for the multiply/divide unit.
// Opcode values match the MDU_* encoding used by the control decoder.
package mul_div_unit_pkg;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_e;

    function automatic logic op_a_signed(input mdu_op_e op);
        return op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
    endfunction

    function automatic logic op_b_signed(input mdu_op_e op);
        return op inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
    endfunction

    function automatic logic op_is_div(input mdu_op_e op);
        return op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
    endfunction

    function automatic logic op_is_rem(input mdu_op_e op);
        return op inside {MDU_REM, MDU_REMU};
    endfunction

endpackage

// File: rtl/mdu_shift_unit.sv
// One add/subtract step shared by the multiply and divide iterations.
// The extra top bit of the full result is the borrow when subtracting.
module mdu_shift_unit #(
    parameter int XLEN = 32
) (
    input  logic            sub,
    input  logic [XLEN:0]   x,
    input  logic [XLEN-1:0] y,
    output logic [XLEN:0]   res,
    output logic            borrow
);

    logic [XLEN+1:0] full;

    always_comb begin
        if (sub) begin
            full = {1'b0, x} - {2'b00, y};
        end else begin
            full = {1'b0, x} + {2'b00, y};
        end
    end

    assign res    = full[XLEN:0];
    assign borrow = full[XLEN+1];

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle RV32M multiply/divide unit: one bit per cycle on operand magnitudes,
// sign fix-up at the end, valid/ready on both request and response sides.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_e;

    localparam logic [XLEN-1:0]  XMIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

    state_e          state;
    mdu_op_e         op_q;
    logic            neg_q;
    logic            special_q;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic [XLEN-1:0] mag;

    mdu_op_e         in_op;
    logic            in_sa;
    logic            in_sb;
    logic            in_div;
    logic            in_rem;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] special_val;

    logic            unit_sub;
    logic [XLEN:0]   unit_x;
    logic [XLEN-1:0] unit_y;
    logic [XLEN:0]   unit_res;
    logic            unit_borrow;

    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   final_val;

    // Request decode: operand signs, magnitudes and the cases answered without iterating.
    always_comb begin
        in_op    = mdu_op_e'(req_op);
        in_sa    = op_a_signed(in_op) & req_a[XLEN-1];
        in_sb    = op_b_signed(in_op) & req_b[XLEN-1];
        a_mag    = in_sa ? -req_a : req_a;
        b_mag    = in_sb ? -req_b : req_b;
        in_div   = op_is_div(in_op);
        in_rem   = op_is_rem(in_op);
        div_zero = in_div && (req_b == '0);
        div_ovf  = in_div && op_b_signed(in_op) && (req_a == XMIN) && (req_b == '1);
        special_val = '0;
        if (div_zero) begin
            special_val = in_rem ? req_a : '1;
        end else if (div_ovf) begin
            special_val = in_rem ? '0 : XMIN;
        end
    end

    // Divide shifts the next dividend bit into the partial remainder; multiply adds |a| when the low bit is set.
    always_comb begin
        unit_sub = (state == ST_DIV);
        unit_x   = unit_sub ? {acc_hi, acc_lo[XLEN-1]} : {1'b0, acc_hi};
        unit_y   = (unit_sub || acc_lo[0]) ? mag : '0;
    end

    mdu_shift_unit #(
        .XLEN(XLEN)
    ) u_shift (
        .sub   (unit_sub),
        .x     (unit_x),
        .y     (unit_y),
        .res   (unit_res),
        .borrow(unit_borrow)
    );

    always_comb begin
        prod   = {acc_hi, acc_lo};
        prod_s = neg_q ? -prod : prod;
        quot_s = neg_q ? -acc_lo : acc_lo;
        rem_s  = neg_q ? -acc_hi : acc_hi;
        case (op_q)
            MDU_MUL:                         final_val = prod_s[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: final_val = prod_s[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:               final_val = quot_s;
            default:                         final_val = rem_s;
        endcase
        if (special_q) begin
            final_val = acc_lo;
        end
    end

    // Control and datapath registers; DONE spends its first cycle publishing the sign-corrected result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_result <= '0;
            op_q        <= MDU_MUL;
            neg_q       <= 1'b0;
            special_q   <= 1'b0;
            cnt         <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            mag         <= '0;
        end else if (flush) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        op_q      <= in_op;
                        neg_q     <= in_rem ? in_sa : (in_sa ^ in_sb);
                        special_q <= div_zero || div_ovf;
                        cnt       <= '0;
                        req_ready <= 1'b0;
                        acc_hi    <= '0;
                        if (div_zero || div_ovf) begin
                            acc_lo <= special_val;
                            state  <= ST_DONE;
                        end else if (in_div) begin
                            acc_lo <= a_mag;
                            mag    <= b_mag;
                            state  <= ST_DIV;
                        end else begin
                            acc_lo <= b_mag;
                            mag    <= a_mag;
                            state  <= ST_MUL;
                        end
                    end
                end
                ST_MUL: begin
                    acc_hi <= unit_res[XLEN:1];
                    acc_lo <= {unit_res[0], acc_lo[XLEN-1:1]};
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        state <= ST_DONE;
                    end
                end
                ST_DIV: begin
                    if (!unit_borrow) begin
                        acc_hi <= unit_res[XLEN-1:0];
                        acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
                    end else begin
                        acc_hi <= unit_x[XLEN-1:0];
                        acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    if (!resp_valid) begin
                        resp_valid  <= 1'b1;
                        resp_result <= final_val;
                    end else if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected results come from a 64-bit arithmetic
// reference model and are checked by an independent monitor, including latency.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    localparam logic [31:0] XMIN = 32'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;

    typedef struct {
        logic [31:0] result;
        int          latency;
        int          accept;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_accept = 0;
    int   last_hs = 0;
    bit   stall = 0;
    bit   bp_en = 0;

    mul_div_unit #(
        .XLEN (32),
        .CNT_W(6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_result(resp_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb_;
        longint      ub;
        longint      p;
        logic [63:0] ua64;
        logic [63:0] ub64;
        logic [63:0] up;
        int          ia;
        int          ib;
        logic [31:0] r;
        sa   = longint'($signed(a));
        sb_  = longint'($signed(b));
        ub   = longint'({32'b0, b});
        ua64 = {32'b0, a};
        ub64 = {32'b0, b};
        ia   = a;
        ib   = b;
        r    = '0;
        case (op)
            3'd0: begin p = sa * sb_; r = p[31:0]; end
            3'd1: begin p = sa * sb_; r = p[63:32]; end
            3'd2: begin p = sa * ub;  r = p[63:32]; end
            3'd3: begin up = ua64 * ub64; r = up[63:32]; end
            3'd4: begin
                if (b == 0) r = '1;
                else if (a == XMIN && b == '1) r = XMIN;
                else r = ia / ib;
            end
            3'd5: r = (b == 0) ? '1 : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == XMIN && b == '1) r = '0;
                else r = ia % ib;
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int refLatency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op >= 3'd4 && (b == 0 || ((op == 3'd4 || op == 3'd6) && a == XMIN && b == '1))) return 1;
        return 33;
    endfunction

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit track);
        int   waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            checkOutput("req_ready_timeout", req_ready, 1);
            return;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(negedge clk);
        req_valid   = 1'b0;
        last_accept = cyc;
        if (track) begin
            e.result  = refModel(op, a, b);
            e.latency = refLatency(op, a, b);
            e.accept  = cyc;
            e.name    = $sformatf("op%0d a=%h b=%h", op, a, b);
            sb.push_back(e);
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((sb.size() != 0 || !req_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", sb.size(), 0);
    endtask

    // Response-side handshake driver, updated just after each rising edge.
    initial begin
        resp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (stall) resp_ready = 1'b0;
            else if (bp_en) resp_ready = ($urandom_range(0, 3) != 0);
            else resp_ready = 1'b1;
        end
    end

    // Monitor: pops the scoreboard when a response first appears, then checks it holds until consumed.
    initial begin
        bit          in_resp;
        bit          have_exp;
        logic [31:0] held;
        exp_t        e;
        in_resp  = 0;
        have_exp = 0;
        held     = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_resp = 0;
                continue;
            end
            if (resp_valid) begin
                if (!in_resp) begin
                    in_resp = 1;
                    if (sb.size() == 0) begin
                        have_exp = 0;
                        checkOutput("unexpected_resp", resp_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        have_exp = 1;
                        held = e.result;
                        checkOutput({"result ", e.name}, resp_result, e.result);
                        checkOutput({"latency ", e.name}, cyc - e.accept, e.latency);
                    end
                end else if (have_exp) begin
                    checkOutput("held_result", resp_result, held);
                    checkOutput("req_ready_in_done", req_ready, 0);
                end
                if (resp_ready) last_hs = cyc + 1;
            end else begin
                in_resp = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          rose;
        int          n;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          sel;

        rst_n = 1'b0;
        flush = 1'b0;
        req_valid = 1'b0;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_req_ready", req_ready, 1);
        checkOutput("reset_resp_valid", resp_valid, 0);
        checkOutput("reset_resp_result", resp_result, 0);
        rst_n = 1'b1;

        applyStimulus(MDU_MUL,    32'd7, -32'sd3, 1);
        applyStimulus(MDU_MULH,   32'd7, -32'sd3, 1);
        applyStimulus(MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        applyStimulus(MDU_MULHSU, 32'hFFFF_FFFF, 32'd2, 1);
        applyStimulus(MDU_DIV,   -32'sd7, 32'd2, 1);
        applyStimulus(MDU_REM,   -32'sd7, 32'd2, 1);
        applyStimulus(MDU_DIVU,   32'd100, 32'd7, 1);
        applyStimulus(MDU_REMU,   32'd100, 32'd7, 1);
        applyStimulus(MDU_DIV,    32'd5, 32'd0, 1);
        applyStimulus(MDU_REM,    32'd5, 32'd0, 1);
        applyStimulus(MDU_DIVU,   32'd5, 32'd0, 1);
        applyStimulus(MDU_REMU,   32'd5, 32'd0, 1);
        applyStimulus(MDU_DIV,    XMIN, 32'hFFFF_FFFF, 1);
        applyStimulus(MDU_REM,    XMIN, 32'hFFFF_FFFF, 1);
        applyStimulus(MDU_MULH,   XMIN, XMIN, 1);
        applyStimulus(MDU_DIVU,   XMIN, 32'hFFFF_FFFF, 1);
        waitDrain();

        // Hold the result with resp_ready low, then release and issue the next op right away.
        stall = 1;
        applyStimulus(MDU_DIVU, 32'd100, 32'd7, 1);
        n = 0;
        while (!resp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("stall_resp_seen", resp_valid, 1);
        repeat (10) begin
            @(negedge clk);
            checkOutput("stall_valid_held", resp_valid, 1);
        end
        stall = 0;
        applyStimulus(MDU_MUL, 32'd6, 32'd7, 1);
        checkOutput("accept_after_hs", last_accept, last_hs + 1);
        waitDrain();

        // Flush around iteration 10 with a competing request that must be dropped.
        applyStimulus(MDU_DIV, 32'd12345, 32'd17, 0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        req_valid = 1'b1;
        req_op = MDU_MUL;
        req_a = 32'd3;
        req_b = 32'd3;
        @(negedge clk);
        flush = 1'b0;
        req_valid = 1'b0;
        checkOutput("flush_req_ready", req_ready, 1);
        checkOutput("flush_resp_valid", resp_valid, 0);
        rose = 0;
        repeat (40) begin
            @(negedge clk);
            if (resp_valid) rose = 1;
        end
        checkOutput("flush_no_resp", rose, 0);
        applyStimulus(MDU_DIVU, 32'd100, 32'd7, 1);
        waitDrain();

        // Asynchronous reset in the middle of a divide.
        applyStimulus(MDU_DIV, -32'sd1000, 32'd7, 0);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_resp_valid", resp_valid, 0);
        checkOutput("midreset_req_ready", req_ready, 1);
        checkOutput("midreset_resp_result", resp_result, 0);
        @(negedge clk);
        rst_n = 1'b1;

        bp_en = 1;
        for (int i = 0; i < 40; i++) begin
            op  = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            a   = $urandom;
            b   = $urandom;
            if (sel == 0) b = '0;
            else if (sel == 1) begin a = XMIN; b = '1; end
            else if (sel == 2) begin
                a = 32'($signed($urandom_range(0, 200)) - 100);
                b = 32'($signed($urandom_range(0, 20)) - 10);
            end
            applyStimulus(op, a, b, 1);
        end
        waitDrain();
        bp_en = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
